// File: rtl/barcodescanner_nios_pio_out.sv
// barcodescanner_nios_pio_out
// Avalon-MM output PIO with atomic set/clear, programmable reset value and
// an optional per-bit blink engine.
// Build option: define PIO_OUT_BLINK_EN to include the blink engine together
// with the BMASK (addr 3) and PERIOD (addr 4) registers. Without it those
// addresses read 0, writes to them are ignored and out_port follows DATA.
module barcodescanner_nios_pio_out #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 PERIOD_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_BMASK  = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;

    // Bits of writedata above WIDTH/PERIOD_W are intentionally dropped.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    // DATA register with atomic set/clear aliases.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_VAL;
        end else if (wr) begin
            case (address)
                ADDR_DATA:  data_out <= wd;
                ADDR_SET:   data_out <= data_out | wd;
                ADDR_CLEAR: data_out <= data_out & ~wd;
                default:    ;
            endcase
        end
    end

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0]    blink_mask;
    logic [PERIOD_W-1:0] half_period;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_m1;
    logic                phase;

    assign period_m1 = half_period - PERIOD_W'(1);

    // Blink mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask <= '0;
        end else if (wr && address == ADDR_BMASK) begin
            blink_mask <= wd;
        end
    end

    // Half-period prescaler; a PERIOD write always restarts the count, even
    // on a terminal-count cycle or when rewriting the same value.
    always_ff @(posedge clk) begin
        if (reset) begin
            half_period <= '0;
            cnt         <= '0;
            phase       <= 1'b1;
        end else if (wr && address == ADDR_PERIOD) begin
            half_period <= writedata[PERIOD_W-1:0];
            cnt         <= '0;
            phase       <= 1'b1;
        end else if (half_period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period_m1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    assign out_port = data_out & (~blink_mask | {WIDTH{phase}});

    // Zero-latency register readback.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]    = data_out;
            ADDR_BMASK:  readdata[WIDTH-1:0]    = blink_mask;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = half_period;
            default:     ;
        endcase
    end
`else
    logic [PERIOD_W-1:0] unused_period;
    assign unused_period = writedata[PERIOD_W-1:0];

    assign out_port = data_out;

    // Zero-latency register readback; blink registers absent.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = data_out;
            default:   ;
        endcase
    end
`endif

endmodule

// File: tb/tb_barcodescanner_nios_pio_out.sv
// Directed self-checking bench for barcodescanner_nios_pio_out
// (WIDTH=8, RESET_VAL=8'hA5, PERIOD_W=24). Blink scenarios are exercised
// when PIO_OUT_BLINK_EN is defined, the plain-port scenario otherwise.
module tb_barcodescanner_nios_pio_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;

    barcodescanner_nios_pio_out #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5),
        .PERIOD_W  (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write is captured on the next posedge and the
    // task returns at the following negedge, where its effect is visible.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [8];
        exp_rd = '{32'h0000_00A5, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_out: got %h want a5", out_port);
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            n_checks++;
            if (readdata !== exp_rd[a]) begin
                n_fail++;
                $display("FAIL reset_read@%0d: got %h want %h", a, readdata, exp_rd[a]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_data_set_clear();
        logic [2:0]  wa  [5];
        logic [31:0] wdv [5];
        logic [7:0]  exp [5];
        wa  = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd7};
        wdv = '{32'hFFFF_FF3C, 32'h0000_0081, 32'h0000_000C, 32'h0000_00FF, 32'h0000_0000};
        exp = '{8'h3C, 8'hBD, 8'hB1, 8'hB1, 8'hB1};
        for (int i = 0; i < 5; i++) begin
            do_write(wa[i], wdv[i]);
            n_checks++;
            if (out_port !== exp[i]) begin
                n_fail++;
                $display("FAIL dsc_out[%0d]: got %h want %h", i, out_port, exp[i]);
            end
        end
        // Write strobe without chipselect must be ignored.
        address = 3'd0; writedata = 32'h0; write_n = 1'b0; chipselect = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        n_checks++;
        if (out_port !== 8'hB1) begin
            n_fail++;
            $display("FAIL no_cs_write: got %h want b1", out_port);
        end
        address = 3'd0; #1;
        n_checks++;
        if (readdata !== 32'h0000_00B1) begin
            n_fail++;
            $display("FAIL read_data: got %h want 000000b1", readdata);
        end
        for (int a = 1; a < 3; a++) begin
            address = 3'(a); #1;
            n_checks++;
            if (readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL read_setclr@%0d: got %h want 0", a, readdata);
            end
        end
        @(negedge clk);
    endtask

`ifdef PIO_OUT_BLINK_EN
    task automatic test_blink();
        logic [7:0] exp [12];
        exp = '{8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0,
                8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0};
        do_write(3'd0, 32'h0000_00FF);
        do_write(3'd3, 32'h0000_000F);
        do_write(3'd4, 32'h0000_0003);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (out_port !== exp[k]) begin
                n_fail++;
                $display("FAIL blink3[%0d]: got %h want %h", k, out_port, exp[k]);
            end
        end
        address = 3'd3; #1;
        n_checks++;
        if (readdata !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL read_bmask: got %h want 0000000f", readdata);
        end
        address = 3'd4; #1;
        n_checks++;
        if (readdata !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL read_period: got %h want 00000003", readdata);
        end
    endtask

    task automatic test_period_rewrite();
        logic [7:0] exp [7];
        exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0};
        // Phase is 0 here (out_port == F0); PERIOD write resyncs to phase 1.
        do_write(3'd4, 32'h0000_0005);
        for (int m = 0; m < 7; m++) begin
            if (m > 0) @(negedge clk);
            n_checks++;
            if (out_port !== exp[m]) begin
                n_fail++;
                $display("FAIL blink5[%0d]: got %h want %h", m, out_port, exp[m]);
            end
        end
        do_write(3'd4, 32'h0000_0000);
        for (int m = 0; m < 10; m++) begin
            if (m > 0) @(negedge clk);
            n_checks++;
            if (out_port !== 8'hFF) begin
                n_fail++;
                $display("FAIL blink_off[%0d]: got %h want ff", m, out_port);
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        do_write(3'd4, 32'h0000_0002);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_port !== 8'hF0) begin
            n_fail++;
            $display("FAIL pre_reset_phase0: got %h want f0", out_port);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_mid_blink: got %h want a5", out_port);
        end
        for (int a = 3; a < 5; a++) begin
            address = 3'(a); #1;
            n_checks++;
            if (readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read@%0d: got %h want 0", a, readdata);
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_steady: got %h want a5", out_port);
        end
    endtask
`else
    task automatic test_no_blink();
        do_write(3'd3, 32'h0000_00FF);
        do_write(3'd4, 32'h0000_0002);
        for (int m = 0; m < 8; m++) begin
            if (m > 0) @(negedge clk);
            n_checks++;
            if (out_port !== 8'hB1) begin
                n_fail++;
                $display("FAIL noblink_out[%0d]: got %h want b1", m, out_port);
            end
        end
        for (int a = 3; a < 5; a++) begin
            address = 3'(a); #1;
            n_checks++;
            if (readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL noblink_read@%0d: got %h want 0", a, readdata);
            end
        end
        @(negedge clk);
        do_write(3'd0, 32'h0000_0055);
        n_checks++;
        if (out_port !== 8'h55) begin
            n_fail++;
            $display("FAIL noblink_data: got %h want 55", out_port);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        @(negedge clk);
        test_reset();
        test_data_set_clear();
`ifdef PIO_OUT_BLINK_EN
        test_blink();
        test_period_rewrite();
        test_reset_mid_blink();
`else
        test_no_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
